// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding and widths for the bus arbiter
package bus_arb_pkg;
    localparam int ARB_STATE_W = 2;
    localparam int ARB_DBG_W   = 4;

    typedef enum logic [ARB_STATE_W-1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;
endpackage

// File: rtl/bus_arbiter_ctrl_if.sv
// bus_arbiter_ctrl_if: request/grant/occupancy bundle between bus masters and the arbiter
interface bus_arbiter_ctrl_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ID_W        = 2
);
    logic [NUM_MASTERS-1:0] b_request;
    logic                   bus_util;
    logic [NUM_MASTERS-1:0] b_grant;
    logic [ID_W-1:0]        grant_id;
    logic                   grant_valid;
    logic [ARB_DBG_W-1:0]   arb_state;
    logic                   err_timeout;
    logic                   err_hold;

    modport slave (
        input  b_request, bus_util,
        output b_grant, grant_id, grant_valid, arb_state, err_timeout, err_hold
    );

    modport master (
        output b_request, bus_util,
        input  b_grant, grant_id, grant_valid, arb_state, err_timeout, err_hold
    );
endinterface

// File: rtl/arb_pick.sv
// arb_pick: picks the first requester searching upward from a start index (start ignored unless ARB_ROUND_ROBIN_EN)
module arb_pick #(
    parameter int N    = 3,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] start,
    output logic [N-1:0]    onehot,
    output logic [ID_W-1:0] idx
);
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [ID_W-1:0] base;
    logic [IW-1:0]   j;
    logic            found;

    assign base = start & {ID_W{RR}};

    // walk the requesters in wrap-around order from base, first hit wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(base) + i) % N);
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = ID_W'(j);
            end
        end
    end
endmodule

// File: rtl/bus_arbiter_ctrl.sv
// bus_arbiter_ctrl: shared-bus arbiter with grant timeout and hold watchdog; ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module bus_arbiter_ctrl
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 3,
    parameter int ID_W          = 2,
    parameter int GRANT_TIMEOUT = 8,
    parameter int HOLD_W        = 10
) (
    input logic               clk,
    input logic               rst,
    bus_arbiter_ctrl_if.slave bus
);
    localparam int WAIT_W = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(GRANT_TIMEOUT - 1);

    arb_state_e             state, state_n;
    logic [WAIT_W-1:0]      wait_cnt, wait_n;
    logic [HOLD_W-1:0]      hold_cnt, hold_n, hold_inc;
    logic [NUM_MASTERS-1:0] grant, grant_n, win_oh;
    logic [ID_W-1:0]        id, id_n, win_idx, rr_ptr;
    logic                   err_to, err_to_n, err_ho, err_ho_n;

    arb_pick #(.N(NUM_MASTERS), .ID_W(ID_W)) u_pick (
        .req    (bus.b_request),
        .start  (rr_ptr),
        .onehot (win_oh),
        .idx    (win_idx)
    );

`ifdef ARB_ROUND_ROBIN_EN
    // next search starts just past the latest winner, whatever became of that grant
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (state == IDLE && state_n == GRANT)
            rr_ptr <= (win_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
    end
`else
    assign rr_ptr = '0;
`endif

    assign hold_inc        = hold_cnt + 1'b1;
    assign bus.b_grant     = grant;
    assign bus.grant_id    = id;
    assign bus.grant_valid = |grant;
    assign bus.arb_state   = {{(ARB_DBG_W - ARB_STATE_W){1'b0}}, state};
    assign bus.err_timeout = err_to;
    assign bus.err_hold    = err_ho;

    // state, counters, grant and error pulses are all registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            id       <= '0;
            err_to   <= 1'b0;
            err_ho   <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            hold_cnt <= hold_n;
            grant    <= grant_n;
            id       <= id_n;
            err_to   <= err_to_n;
            err_ho   <= err_ho_n;
        end
    end

    // next state; every exit zeroes the counter of the state being left
    always_comb begin
        state_n  = state;
        wait_n   = wait_cnt;
        hold_n   = hold_cnt;
        grant_n  = grant;
        id_n     = id;
        err_to_n = 1'b0;
        err_ho_n = 1'b0;
        case (state)
            IDLE: begin
                if (|bus.b_request && bus.bus_util) begin
                    state_n = GRANT;
                    grant_n = win_oh;
                    id_n    = win_idx;
                end
            end
            GRANT: begin
                wait_n = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
                if (!bus.bus_util) begin
                    state_n = BUSY;
                    wait_n  = '0;
                end else if (!(|(bus.b_request & grant))) begin
                    state_n = IDLE;
                    wait_n  = '0;
                    grant_n = '0;
                    id_n    = '0;
                end else if (wait_cnt == WAIT_MAX) begin
                    state_n  = IDLE;
                    wait_n   = '0;
                    grant_n  = '0;
                    id_n     = '0;
                    err_to_n = 1'b1;
                end
            end
            BUSY: begin
                hold_n = (&hold_cnt) ? hold_cnt : hold_inc;
                if (bus.bus_util || &hold_inc) begin
                    state_n  = RELEASE;
                    hold_n   = '0;
                    grant_n  = '0;
                    id_n     = '0;
                    err_ho_n = !bus.bus_util;
                end
            end
            RELEASE: begin
                if (bus.bus_util)
                    state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// tb_bus_arbiter_ctrl: directed checks of bus_arbiter_ctrl (HOLD_W=4); expects ARB_ROUND_ROBIN_EN to match the RTL build
module tb_bus_arbiter_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    bus_arbiter_ctrl_if #(.NUM_MASTERS(3), .ID_W(2)) bus ();

    bus_arbiter_ctrl #(
        .NUM_MASTERS   (3),
        .ID_W          (2),
        .GRANT_TIMEOUT (8),
        .HOLD_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {grant, id, valid, state, err_timeout, err_hold}
    function automatic logic [31:0] outs();
        return {20'd0, bus.b_grant, bus.grant_id, bus.grant_valid, bus.arb_state, bus.err_timeout, bus.err_hold};
    endfunction

    function automatic logic [31:0] pack(input logic [2:0] g, input logic [1:0] i, input logic [3:0] s,
                                         input logic et, input logic eh);
        return {20'd0, g, i, |g, s, et, eh};
    endfunction

    initial begin
        logic [1:0] rr_exp [4];
`ifdef ARB_ROUND_ROBIN_EN
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
        rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        rst = 1'b1;
        bus.b_request = '0;
        bus.bus_util = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset", outs(), pack(3'b000, 2'd0, 4'd0, 1'b0, 1'b0));

        // request from masters 1 and 2, bus free
        bus.b_request = 3'b110;
        tick();
        check("grant_first", outs(), pack(3'b010, 2'd1, 4'd1, 1'b0, 1'b0));

        // bus taken for three cycles then released
        bus.bus_util = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("busy_%0d", i), outs(), pack(3'b010, 2'd1, 4'd2, 1'b0, 1'b0));
        end
        bus.bus_util = 1'b1;
        bus.b_request = '0;
        tick();
        check("release", outs(), pack(3'b000, 2'd0, 4'd3, 1'b0, 1'b0));
        tick();
        check("back_idle", outs(), pack(3'b000, 2'd0, 4'd0, 1'b0, 1'b0));

        // grant never used: revoked after eight GRANT cycles
        bus.b_request = 3'b001;
        tick();
        check("to_grant", outs(), pack(3'b001, 2'd0, 4'd1, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++) tick();
        check("to_still_grant", outs(), pack(3'b001, 2'd0, 4'd1, 1'b0, 1'b0));
        tick();
        check("to_pulse", outs(), pack(3'b000, 2'd0, 4'd0, 1'b1, 1'b0));
        bus.b_request = '0;
        tick();
        check("to_pulse_end", outs(), pack(3'b000, 2'd0, 4'd0, 1'b0, 1'b0));

        // requester withdraws while granted: quiet return to IDLE
        bus.b_request = 3'b100;
        tick();
        check("drop_grant", outs(), pack(3'b100, 2'd2, 4'd1, 1'b0, 1'b0));
        bus.b_request = '0;
        tick();
        check("drop_idle", outs(), pack(3'b000, 2'd0, 4'd0, 1'b0, 1'b0));

        // bus already occupied by someone else: no grant
        bus.bus_util = 1'b0;
        bus.b_request = 3'b001;
        tick();
        check("foreign_busy", outs(), pack(3'b000, 2'd0, 4'd0, 1'b0, 1'b0));

        // all three request continuously; short transactions
        bus.bus_util = 1'b1;
        bus.b_request = 3'b111;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("order_%0d", i), outs(), pack(3'b001 << rr_exp[i], rr_exp[i], 4'd1, 1'b0, 1'b0));
            bus.bus_util = 1'b0;
            tick();
            bus.bus_util = 1'b1;
            tick();
            tick();
        end

        // hold watchdog: bus never released, trips on the 15th BUSY cycle
        bus.b_request = 3'b010;
        tick();
        bus.bus_util = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("hold_still_busy", outs(), pack(3'b010, 2'd1, 4'd2, 1'b0, 1'b0));
        tick();
        check("hold_pulse", outs(), pack(3'b000, 2'd0, 4'd3, 1'b0, 1'b1));
        tick();
        check("hold_release_wait", outs(), pack(3'b000, 2'd0, 4'd3, 1'b0, 1'b0));
        bus.bus_util = 1'b1;
        tick();
        check("hold_idle", outs(), pack(3'b000, 2'd0, 4'd0, 1'b0, 1'b0));

        // release on the same cycle the watchdog would trip: no error
        tick();
        check("tie_grant", outs(), pack(3'b010, 2'd1, 4'd1, 1'b0, 1'b0));
        bus.bus_util = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        bus.bus_util = 1'b1;
        tick();
        check("tie_release", outs(), pack(3'b000, 2'd0, 4'd3, 1'b0, 1'b0));
        tick();

        // reset in the middle of BUSY
        tick();
        bus.bus_util = 1'b0;
        tick();
        check("pre_rst_busy", outs(), pack(3'b010, 2'd1, 4'd2, 1'b0, 1'b0));
        rst = 1'b1;
        tick();
        check("mid_rst", outs(), pack(3'b000, 2'd0, 4'd0, 1'b0, 1'b0));
        rst = 1'b0;
        bus.b_request = '0;
        bus.bus_util = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
